ps2_rx_frame: RTL
=================

PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synced ps2_clk samples required before the filtered clock changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: max clk cycles between falling edges inside a frame; counter width 16 bits.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ps2_clk  input  1  raw asynchronous keyboard clock line.
REQ-006 ps2_data  input  1  raw asynchronous keyboard data line.
REQ-007 rx_en  input  1  receive enable; low while the host transmitter drives the bus.
REQ-008 rx_byte  output  8  last correctly received data byte.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_byte newly updated.
REQ-010 rx_err  output  1  one-cycle pulse; frame rejected.
REQ-011 err_code  output  2  cause of last rejection: 0 timeout, 1 bad start, 2 parity, 3 bad stop; held until next rx_err.
REQ-012 busy  output  1  high while state is RECV.

Function
REQ-013 Both ps2_clk and ps2_data SHALL pass through 2-flop synchronizers before any use.
REQ-014 Filtered clock SHALL change only after FILTER_LEN consecutive equal synced samples differing from its current value; shorter pulses are ignored.
REQ-015 A sample event SHALL be a 1-to-0 transition of the filtered clock; synced ps2_data is captured in that same cycle.
REQ-016 States: IDLE, RECV; 4-bit bit counter 0..10; frame = start(0), D0..D7 LSB first, odd parity, stop(1).
REQ-017 IDLE: sample event with rx_en=1 and data=0 -> RECV, bitcnt=1; with data=1 -> rx_err pulse, err_code=1, stay IDLE.
REQ-018 RECV: bitcnt 1..8 shift data into byte position bitcnt-1; bitcnt 9 store parity; bitcnt 10 evaluate frame, return to IDLE.
REQ-019 Evaluation priority: stop=0 -> err_code 3; else XOR(D0..D7,parity)=0 -> err_code 2; else success.
REQ-020 Success: rx_byte updated and rx_valid pulsed in the cycle after the stop-bit sample event (latency 1).
REQ-021 Error: rx_err pulsed in the cycle after the detecting sample event; rx_byte unchanged.
REQ-022 rx_valid and rx_err SHALL never be high simultaneously.
REQ-023 Timeout counter SHALL clear on each sample event and on entry to RECV; reaching TIMEOUT_CYCLES in RECV -> rx_err, err_code=0, IDLE.
REQ-024 rx_en low in any state SHALL force IDLE silently (no pulse), clear bitcnt and timeout counter; rx_en low wins over a coincident sample event.
REQ-025 Sample events in IDLE with rx_en=0 SHALL be ignored.
REQ-026 Back-to-back frames SHALL decode with no idle gap required beyond the stop bit.

Reset
REQ-027 rst SHALL set state IDLE, bitcnt 0, timeout counter 0, rx_byte 8'h00, rx_valid 0, rx_err 0, err_code 0, busy 0, filtered clock 1, synchronizer flops 1.
REQ-028 rst mid-frame SHALL discard the partial frame with no pulse; next full frame decodes normally.

Verification
REQ-029 Frame 0x1C, parity 0, stop 1 -> single rx_valid pulse, rx_byte=0x1C, rx_err never high.
REQ-030 Frame 0xF0 with parity 0 (wrong) -> rx_err pulse, err_code=2, rx_byte keeps previous 0x1C; following correct 0xF0 (parity 1) -> rx_valid, rx_byte=0xF0.
REQ-031 Start bit 1 -> rx_err, err_code=1; stop bit 0 on 0x1C -> rx_err, err_code=3.
REQ-032 ps2_clk low glitch of FILTER_LEN-2 cycles mid-frame -> no extra bit; frame 0x5A decodes to rx_byte=0x5A.
REQ-033 Clocking stops after D3 for TIMEOUT_CYCLES -> rx_err, err_code=0, busy=0; next frame 0x29 decodes correctly.
REQ-034 rx_en dropped after D5 (and separately rst asserted after D5) -> no pulse, busy=0; next frame 0x12 -> rx_valid, rx_byte=0x12.

Source files
------------

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the bus,
// decodes 11-bit frames and reports each byte or the reason a frame was rejected.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, filt_prev, fall;
  logic [FW-1:0] fcnt;

  state_t        state, state_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [15:0]   tcnt, tcnt_n;
  logic [7:0]    byte_n;
  logic          valid_n, err_n;
  logic [1:0]    code_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'hF;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      fcnt      <= '0;
    end else begin
      filt_prev <= filt;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fall = filt_prev & ~filt;
  assign busy = (state == RECV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bitcnt   <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tcnt     <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= '0;
    end else begin
      state    <= state_n;
      bitcnt   <= bitcnt_n;
      shreg    <= shreg_n;
      par      <= par_n;
      tcnt     <= tcnt_n;
      rx_byte  <= byte_n;
      rx_valid <= valid_n;
      rx_err   <= err_n;
      err_code <= code_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    tcnt_n   = tcnt;
    byte_n   = rx_byte;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    code_n   = err_code;
    // Host transmitting: abandon any frame silently.
    if (!rx_en) begin
      state_n  = IDLE;
      bitcnt_n = '0;
      tcnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt_n = '0;
          if (fall) begin
            if (!dat_s2) begin
              state_n  = RECV;
              bitcnt_n = 4'd1;
            end else begin
              err_n  = 1'b1;
              code_n = 2'd1;
            end
          end
        end
        RECV: begin
          if (fall) begin
            tcnt_n = '0;
            if (bitcnt >= 4'd1 && bitcnt <= 4'd8) begin
              shreg_n[bitcnt[2:0] - 3'd1] = dat_s2;
              bitcnt_n = bitcnt + 4'd1;
            end else if (bitcnt == 4'd9) begin
              par_n    = dat_s2;
              bitcnt_n = 4'd10;
            end else begin
              state_n  = IDLE;
              bitcnt_n = '0;
              if (!dat_s2) begin
                err_n  = 1'b1;
                code_n = 2'd3;
              end else if (!(^{shreg, par})) begin
                err_n  = 1'b1;
                code_n = 2'd2;
              end else begin
                byte_n  = shreg;
                valid_n = 1'b1;
              end
            end
          end else if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            tcnt_n   = '0;
            err_n    = 1'b1;
            code_n   = 2'd0;
          end else begin
            tcnt_n = tcnt + 16'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
